// File: rtl/regbank_pkg.sv
// Shared defaults and helper functions for the round-robin register-bank write arbiter.
package regbank_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned MAX_REQ     = 32;
  localparam int unsigned MAX_DEPTH   = 64;

  // One-hot grant for the first valid requester at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int unsigned        idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && (((valid >> idx) & MAX_REQ'(1)) != '0)) begin
          g     = MAX_REQ'(1) << idx;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [MAX_DEPTH-1:0] onehot_ce(input logic [31:0] addr,
                                                     input int unsigned depth);
    logic [MAX_DEPTH-1:0] ce;
    ce = '0;
    if (addr < depth) ce = MAX_DEPTH'(1) << addr;
    return ce;
  endfunction

endpackage

// File: rtl/regbank_cell.sv
// One storage register of the bank: loads d_in when ce_in is high, async clear to zero.
module regbank_cell #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ce_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      q_q <= '0;
    end else if (ce_in) begin
      q_q <= d_in;
    end
  end

  assign q_out = q_q;

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter granting NUM_REQ writers access to a shared bank of CE-controlled
// registers; the winning write is staged one cycle, then applied. Registered read port.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter  int unsigned DEPTH   = DEF_DEPTH,
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*AW-1:0]    req_addr_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [AW-1:0]            rd_addr_in,
  output logic [WIDTH-1:0]         rd_data_out,
  output logic                     grant_valid_out,
  output logic [IW-1:0]            grant_id_out,
  output logic                     err_out
);

  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [IW-1:0]      win_idx;
  logic [AW-1:0]      win_addr;
  logic [WIDTH-1:0]   win_data;
  logic               win_oor;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [DEPTH-1:0]   ce_q, ce_d;
  logic [WIDTH-1:0]   wdata_q;
  logic               gv_q;
  logic [IW-1:0]      gid_q;
  logic               err_q;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]   bank [DEPTH];

  // Grant is forced low during reset so nothing is accepted while the bank is cleared.
  always_comb begin
    grant = NUM_REQ'(rr_grant(MAX_REQ'(req_valid_in), 32'(ptr_q), NUM_REQ));
    if (!rst_n_in) grant = '0;
  end

  assign req_ready_out = grant;
  assign accept        = |grant;

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = IW'(i);
        win_addr = req_addr_in[i*AW +: AW];
        win_data = req_data_in[i*WIDTH +: WIDTH];
      end
    end
    win_oor = (32'(win_addr) >= DEPTH);

    ptr_d = ptr_q;
    if (accept) ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

    ce_d = '0;
    if (accept) ce_d = DEPTH'(onehot_ce(32'(win_addr), DEPTH));
  end

  always_comb begin
    rd_d = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (32'(rd_addr_in) == k) rd_d = bank[k];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q   <= '0;
      ce_q    <= '0;
      wdata_q <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      ce_q  <= ce_d;
      gv_q  <= accept;
      rd_q  <= rd_d;
      if (accept) begin
        wdata_q <= win_data;
        gid_q   <= win_idx;
        if (win_oor) err_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_bank
    regbank_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .ce_in   (ce_q[k]),
      .d_in    (wdata_q),
      .q_out   (bank[k])
    );
  end

  assign rd_data_out     = rd_q;
  assign grant_valid_out = gv_q;
  assign grant_id_out    = gid_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: default instance plus a DEPTH=6 instance
// used to exercise out-of-range write addresses.
module tb_regbank_write_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        err;

  logic [3:0]  req_valid6;
  logic [11:0] req_addr6;
  logic [31:0] req_data6;
  logic [3:0]  req_ready6;
  logic [2:0]  rd_addr6;
  logic [7:0]  rd_data6;
  logic        grant_valid6;
  logic [1:0]  grant_id6;
  logic        err6;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  int         exp_id_q[$];
  wr_t        wr_q[$];
  logic [7:0] mbank [8];
  int         mptr;

  regbank_write_arbiter #(
    .NUM_REQ(4),
    .DEPTH  (8),
    .WIDTH  (8)
  ) u_dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .req_valid_in   (req_valid),
    .req_addr_in    (req_addr),
    .req_data_in    (req_data),
    .req_ready_out  (req_ready),
    .rd_addr_in     (rd_addr),
    .rd_data_out    (rd_data),
    .grant_valid_out(grant_valid),
    .grant_id_out   (grant_id),
    .err_out        (err)
  );

  regbank_write_arbiter #(
    .NUM_REQ(4),
    .DEPTH  (6),
    .WIDTH  (8)
  ) u_dut6 (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .req_valid_in   (req_valid6),
    .req_addr_in    (req_addr6),
    .req_data_in    (req_data6),
    .req_ready_out  (req_ready6),
    .rd_addr_in     (rd_addr6),
    .rd_data_out    (rd_data6),
    .grant_valid_out(grant_valid6),
    .grant_id_out   (grant_id6),
    .err_out        (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A requester must not drop valid before it has been accepted.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
                             (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
  end

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mbank[k] = 8'h00;
    mptr = 0;
    exp_id_q.delete();
    wr_q.delete();
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
  endtask

  // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic run_cycle(input bit chk_rd);
    int         w;
    int         id;
    logic [3:0] exp_rdy;
    logic [7:0] exp_rd;
    wr_t        wr;
    #3;
    w       = model_pick(req_valid, mptr);
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    n_tests++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready: got %b expected %b", req_ready, exp_rdy);
    end
    exp_rd = mbank[rd_addr];
    @(posedge clk);
    #1;
    if (wr_q.size() > 0) begin
      wr = wr_q.pop_front();
      mbank[wr.a] = wr.d;
    end
    if (w >= 0) begin
      exp_id_q.push_back(w);
      wr.a = req_addr[w*3 +: 3];
      wr.d = req_data[w*8 +: 8];
      wr_q.push_back(wr);
      mptr = (w + 1) % 4;
    end
    n_tests++;
    if (exp_id_q.size() > 0) begin
      id = exp_id_q.pop_front();
      if (grant_valid !== 1'b1 || grant_id !== 2'(id)) begin
        n_fail++;
        $display("FAIL grant: got valid=%b id=%0d expected valid=1 id=%0d", grant_valid, grant_id, id);
      end
    end else if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_idle: got valid=%b expected 0", grant_valid);
    end
    if (chk_rd) begin
      n_tests++;
      if (rd_data !== exp_rd) begin
        n_fail++;
        $display("FAIL read[%0d]: got %h expected %h", rd_addr, rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    rd_addr    = '0;
    req_valid6 = '0;
    req_addr6  = '0;
    req_data6  = '0;
    rd_addr6   = '0;
    model_reset();
    #1;
    n_tests++;
    if (rd_data !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 2'd0 ||
        err !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got rd=%h gv=%b gid=%0d err=%b rdy=%b expected all 0",
               rd_data, grant_valid, grant_id, err, req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      run_cycle(1);
    end
  endtask

  task automatic test_fairness();
    int wait_c [4];
    int max_wait;
    int w;
    int seq[$];
    int bad;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 3'(i), 8'hC0 | 8'(i));
      wait_c[i] = 0;
    end
    max_wait  = 0;
    req_valid = 4'hF;
    for (int c = 0; c < 24 && req_valid != 4'h0; c++) begin
      w = model_pick(req_valid, mptr);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !req_ready[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      run_cycle(0);
      if (grant_valid === 1'b1) seq.push_back(int'(grant_id));
      if (c >= 8 && w >= 0) req_valid[w] = 1'b0;
    end
    req_valid = '0;
    bad = (seq.size() != 12) ? 1 : 0;
    foreach (seq[j]) if (seq[j] != j % 4) bad = 1;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rr_sequence: got %0d grants %p expected 0,1,2,3 repeating x3", seq.size(), seq);
    end
    n_tests++;
    if (max_wait > 3) begin
      n_fail++;
      $display("FAIL rr_wait: got max wait %0d expected <= 3", max_wait);
    end
  endtask

  task automatic test_contention();
    set_req(1, 3'd3, 8'h11);
    set_req(3, 3'd3, 8'h33);
    req_valid = 4'b1010;
    rd_addr   = 3'd3;
    run_cycle(0);
    n_tests++;
    if (grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL contention_first: got id %0d expected 1", grant_id);
    end
    req_valid[1] = 1'b0;
    run_cycle(0);
    req_valid = '0;
    repeat (3) run_cycle(1);
    n_tests++;
    if (rd_data !== 8'h33) begin
      n_fail++;
      $display("FAIL contention_final: got %h expected 33", rd_data);
    end
  endtask

  task automatic test_single_write();
    set_req(2, 3'd5, 8'hA5);
    req_valid = 4'b0100;
    rd_addr   = 3'd5;
    run_cycle(1);
    req_valid = '0;
    run_cycle(1);
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL no_forward: got %h expected 00", rd_data);
    end
    run_cycle(1);
    n_tests++;
    if (rd_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_read: got %h expected a5", rd_data);
    end
    n_tests++;
    if (grant_id !== 2'd2 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_hold: got id %0d valid %b expected id 2 valid 0", grant_id, grant_valid);
    end
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      run_cycle(1);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp;
    req_valid6      = 4'b0001;
    req_addr6[2:0]  = 3'd2;
    req_data6[7:0]  = 8'h3C;
    #3;
    n_tests++;
    if (req_ready6 !== 4'b0001) begin
      n_fail++;
      $display("FAIL oor_ready_in: got %b expected 0001", req_ready6);
    end
    @(posedge clk);
    #1;
    req_addr6[2:0] = 3'd7;
    req_data6[7:0] = 8'hFF;
    #3;
    n_tests++;
    if (req_ready6 !== 4'b0001) begin
      n_fail++;
      $display("FAIL oor_ready: got %b expected 0001", req_ready6);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (err6 !== 1'b1 || grant_valid6 !== 1'b1 || grant_id6 !== 2'd0) begin
      n_fail++;
      $display("FAIL oor_err: got err=%b gv=%b gid=%0d expected 1 1 0", err6, grant_valid6, grant_id6);
    end
    req_valid6        = 4'b0011;
    req_addr6[5:3]    = 3'd1;
    req_data6[15:8]   = 8'h77;
    #3;
    n_tests++;
    if (req_ready6 !== 4'b0010) begin
      n_fail++;
      $display("FAIL oor_ptr: got %b expected 0010", req_ready6);
    end
    @(posedge clk);
    #1;
    req_valid6 = 4'b0001;
    @(posedge clk);
    #1;
    req_valid6 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (err6 !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_sticky: got %b expected 1", err6);
    end
    for (int k = 0; k < 8; k++) begin
      rd_addr6 = 3'(k);
      exp = (k == 1) ? 8'h77 : (k == 2) ? 8'h3C : 8'h00;
      @(posedge clk);
      #1;
      n_tests++;
      if (rd_data6 !== exp) begin
        n_fail++;
        $display("FAIL oor_bank[%0d]: got %h expected %h", k, rd_data6, exp);
      end
    end
  endtask

  task automatic test_reset_idle();
    rd_addr = 3'd5;
    run_cycle(1);
    run_cycle(1);
    n_tests++;
    if (rd_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL pre_reset_read: got %h expected a5", rd_data);
    end
    #2;
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    n_tests++;
    if (rd_data !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 2'd0 || err !== 1'b0 ||
        req_ready !== 4'b0000 || err6 !== 1'b0 || rd_data6 !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got rd=%h gv=%b gid=%0d err=%b rdy=%b err6=%b rd6=%h expected all 0",
               rd_data, grant_valid, grant_id, err, req_ready, err6, rd_data6);
    end
    req_valid = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      run_cycle(1);
    end
  endtask

  task automatic test_reset_mid_write();
    int w;
    set_req(2, 3'd4, 8'h5A);
    req_valid = 4'b0100;
    run_cycle(0);
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwrite_gv: got %b expected 0", grant_valid);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rd_addr = 3'd4;
    repeat (3) run_cycle(1);
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midwrite_discard: got %h expected 00", rd_data);
    end
    for (int i = 0; i < 4; i++) set_req(i, 3'd6, 8'h60 | 8'(i));
    req_valid = 4'hF;
    for (int c = 0; c < 8 && req_valid != 4'h0; c++) begin
      w = model_pick(req_valid, mptr);
      run_cycle(0);
      if (c == 0) begin
        n_tests++;
        if (grant_id !== 2'd0) begin
          n_fail++;
          $display("FAIL midwrite_ptr: got id %0d expected 0", grant_id);
        end
      end
      if (w >= 0) req_valid[w] = 1'b0;
    end
    n_tests++;
    if (req_valid !== 4'h0) begin
      n_fail++;
      $display("FAIL drain_timeout: got pending %b expected 0000", req_valid);
    end
    req_valid = '0;
    run_cycle(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_contention();
    test_single_write();
    test_out_of_range();
    test_reset_idle();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares one bank of DEPTH enable-controlled storage registers between NUM_REQ independent writers.
- Arbitration is round-robin.
- Each winning write is turned into a one-hot clock-enable plus data, applied to the bank one cycle later.
- A single registered read port returns bank contents.
- Sits between requesting datapath units and the storage they share. It is the sequencer and owner of the bank's CE lines.

Parameters:
- NUM_REQ, 4, number of write requesters (>=2).
- DEPTH, 8, number of storage registers in the bank (>=2, need not be a power of 2).
- WIDTH, 8, data bits per register.
- AW, $clog2(DEPTH), derived address width; not overridden.
- IW, $clog2(NUM_REQ), derived requester-index width; not overridden.

Ports:
- clk_in, input, 1, single clock; all state updates on rising edge.
- rst_n_in, input, 1, reset, asynchronous assert, active-low.
- req_valid_in, input, NUM_REQ, per-requester write request.
- req_addr_in, input, NUM_REQ*AW, flattened per-requester address; requester i occupies bits [i*AW +: AW].
- req_data_in, input, NUM_REQ*WIDTH, flattened per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready_out, output, NUM_REQ, one-hot (or zero) grant; a write is accepted when valid and ready are both high.
- rd_addr_in, input, AW, read address.
- rd_data_out, output, WIDTH, registered read data.
- grant_valid_out, output, 1, registered pulse: a write was accepted in the previous cycle.
- grant_id_out, output, IW, registered index of the last accepted requester; holds between grants.
- err_out, output, 1, sticky flag: an accepted write carried an address >= DEPTH.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - all bank registers = 0
  - rd_data_out = 0, grant_valid_out = 0, grant_id_out = 0, err_out = 0
  - priority pointer = 0
  - pending write stage cleared (an in-flight write is discarded, never applied)
- req_ready_out is combinational from req_valid_in and the pointer.
  - Scan indices pointer, pointer+1, ... mod NUM_REQ; grant the first with valid high.
  - At most one bit set; zero when no valid is high.
  - req_ready_out never asserts for a requester whose valid is low.
  - req_ready_out is 0 while rst_n_in is low.
- Pointer update on accept of requester i: pointer <= (i+1) mod NUM_REQ. With no accept, the pointer holds.
- Requester protocol:
  - Once valid is high, the requester holds valid/addr/data stable until accepted.
  - Deasserting valid before acceptance is illegal; the bench checks it with an assertion.
- Write pipeline, accept in cycle t:
  - Edge ending t: stage captures one-hot ce vector (bit = addr) and data; grant_valid_out <= 1, grant_id_out <= i.
  - Edge ending t+1: bank register addr loads data. All other registers hold.
  - Throughput is one write per cycle. Back-to-back writes to the same address apply in acceptance order, last wins.
- Out-of-range address (addr >= DEPTH):
  - Write is still accepted (ready asserts normally) and the pointer advances.
  - The ce vector is all-zero, so no register changes.
  - err_out <= 1 at edge ending t; stays set until reset.
- Read: at each edge, rd_data_out <= bank[rd_addr_in]. Out-of-range rd_addr_in returns 0.
- No write-to-read forwarding:
  - Data accepted in t is visible on rd_data_out in t+3 when rd_addr_in is presented in t+2.
  - A read presented in t+1 returns the old value.
- Bank cells load only when their ce bit is high; otherwise they hold.

Decomposition:
- Package regbank_pkg holds:
  - default NUM_REQ/DEPTH/WIDTH localparams
  - a function computing the round-robin winner from a valid vector and pointer
  - a function onehot_ce(addr, DEPTH) returning zero for out-of-range addresses
- Sub-module regbank_cell: one WIDTH-bit enable-controlled register with async active-low clear to 0.
  - Ports: clk_in, rst_n_in, ce_in, d_in, q_out.
  - Instantiated DEPTH times by a generate loop.

Test Plan:
- Reset/idle: rst_n_in low mid-run with bank written → all outputs 0 immediately; after release, reading addr 0..7 returns 0x00; ready stays 0 with no valid.
- Single write: requester 2 writes addr 5 = 0xA5 in cycle t → ready[2]=1 in t; grant_valid_out=1 and grant_id_out=2 in t+1; rd_addr=5 presented in t+2 → rd_data_out=0xA5 in t+3; other addresses remain 0.
- Round-robin fairness: all 4 valid continuously, each writing its own address → grants 0,1,2,3,0,1… one per cycle; no requester waits more than 3 cycles.
- Contention on one address: requester 1 writes addr 3 = 0x11 and requester 3 writes addr 3 = 0x33, both valid from pointer 0 → requester 1 wins first, requester 3 next cycle; final bank[3]=0x33.
- Out-of-range: DEPTH=6, requester 0 writes addr 7 = 0xFF → accepted; err_out=1 from next cycle and sticky; all bank registers unchanged.
- Reset mid-write: accept a write to addr 4 = 0x5A, assert rst_n_in in the following cycle before the bank edge → after release bank[4]=0x00, pointer=0, err_out=0.
